// File: rtl/mem_stage_if.sv
// Signal bundle between the memory stage and its EX / WB / data-SRAM neighbours.
// The slave modport is the memory stage's view; master is the surrounding pipeline.
interface mem_stage_if #(
  parameter int ES_TO_MS_WD = 171
);
  logic                   flush;
  logic                   ws_allowin;
  logic                   ms_allowin;
  logic                   es_to_ms_valid;
  logic [ES_TO_MS_WD-1:0] es_to_ms_bus;
  logic                   data_sram_data_ok;
  logic [31:0]            data_sram_rdata;
  logic                   ms_to_ws_valid;
  logic [ES_TO_MS_WD-1:0] ms_to_ws_bus;
  logic [39:0]            ms_forward;
  logic                   ms_to_es_ex;

  modport slave (
    input  flush, ws_allowin, es_to_ms_valid, es_to_ms_bus,
           data_sram_data_ok, data_sram_rdata,
    output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_forward, ms_to_es_ex
  );

  modport master (
    output flush, ws_allowin, es_to_ms_valid, es_to_ms_bus,
           data_sram_data_ok, data_sram_rdata,
    input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_forward, ms_to_es_ex
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: waits for the data-SRAM response, buffers it across WB
// stalls, extends load data, and discards late responses of flushed requests.
module mem_stage #(
  parameter int ES_TO_MS_WD = 171,
  parameter int ERTN_BIT    = 80
) (
  input  logic       clk,
  input  logic       resetn,
  mem_stage_if.slave ms_if
);
  localparam int WD = ES_TO_MS_WD;

  logic          ms_valid_q, ms_valid_d;
  logic [WD-1:0] bus_q, bus_d;
  logic          buf_valid_q, buf_valid_d;
  logic [31:0]   buf_data_q, buf_data_d;
  logic [1:0]    drop_cnt_q, drop_cnt_d;

  logic        res_from_mem, is_store, ex, gr_we;
  logic [1:0]  addr;
  logic        req_issued, live_ok, drop_rsp, ms_ready_go, ms_stall, leave;
  logic        orphan_ms, orphan_es;
  logic [2:0]  drop_sum;
  logic [31:0] raw, loaded, final_result;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign gr_we        = bus_q[69];
  assign res_from_mem = bus_q[70];
  assign addr         = bus_q[77:76];
  assign is_store     = bus_q[78];
  assign ex           = bus_q[79];

  assign req_issued  = ms_valid_q & (res_from_mem | is_store) & ~ex;
  assign live_ok     = ms_if.data_sram_data_ok & (drop_cnt_q == 2'd0);
  assign drop_rsp    = ms_if.data_sram_data_ok & (drop_cnt_q != 2'd0);
  assign ms_ready_go = ~req_issued | buf_valid_q | live_ok;
  assign ms_stall    = ms_valid_q & res_from_mem & ~ms_ready_go;

  assign ms_if.ms_allowin     = ~ms_valid_q | (ms_ready_go & ms_if.ws_allowin);
  assign ms_if.ms_to_ws_valid = ms_valid_q & ms_ready_go & ~ms_if.flush;
  assign leave                = ms_if.ms_to_ws_valid & ms_if.ws_allowin;

  always_comb begin
    raw     = buf_valid_q ? buf_data_q : ms_if.data_sram_rdata;
    rd_half = addr[1] ? raw[31:16] : raw[15:0];
    case (addr)
      2'd0:    rd_byte = raw[7:0];
      2'd1:    rd_byte = raw[15:8];
      2'd2:    rd_byte = raw[23:16];
      default: rd_byte = raw[31:24];
    endcase
    if (bus_q[75])      loaded = raw;
    else if (bus_q[74]) loaded = {{24{rd_byte[7]}}, rd_byte};
    else if (bus_q[73]) loaded = {24'd0, rd_byte};
    else if (bus_q[72]) loaded = {{16{rd_half[15]}}, rd_half};
    else if (bus_q[71]) loaded = {16'd0, rd_half};
    else                loaded = raw;
    final_result = res_from_mem ? loaded : bus_q[63:32];
  end

  assign ms_if.ms_to_ws_bus = {bus_q[WD-1:70], gr_we & ~ex, bus_q[68:64],
                               final_result, bus_q[31:0]};
  assign ms_if.ms_forward   = {ms_stall, final_result, bus_q[68:64], gr_we, ms_valid_q};
  assign ms_if.ms_to_es_ex  = ms_valid_q & (ex | bus_q[ERTN_BIT]);

  // An EX mem-op already holds an accepted request, so on flush it is orphaned even
  // when MS cannot take it this cycle.
  assign orphan_ms = req_issued & ~buf_valid_q & ~live_ok;
  assign orphan_es = ms_if.es_to_ms_valid & (ms_if.es_to_ms_bus[70] | ms_if.es_to_ms_bus[78])
                     & ~ms_if.es_to_ms_bus[79];

  always_comb begin
    ms_valid_d  = ms_valid_q;
    bus_d       = bus_q;
    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;
    if (ms_if.flush) begin
      ms_valid_d = 1'b0;
    end else if (ms_if.ms_allowin) begin
      ms_valid_d = ms_if.es_to_ms_valid;
      if (ms_if.es_to_ms_valid) bus_d = ms_if.es_to_ms_bus;
    end
    if (ms_if.flush | leave) begin
      buf_valid_d = 1'b0;
    end else if (live_ok & req_issued & ~buf_valid_q & ~ms_if.ws_allowin) begin
      buf_valid_d = 1'b1;
      buf_data_d  = ms_if.data_sram_rdata;
    end
    drop_sum = {1'b0, drop_cnt_q};
    if (ms_if.flush) drop_sum = drop_sum + {2'b0, orphan_ms} + {2'b0, orphan_es};
    if (drop_rsp)    drop_sum = drop_sum - 3'd1;
    drop_cnt_d = (drop_sum > 3'd3) ? 2'd3 : drop_sum[1:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid_q  <= 1'b0;
      bus_q       <= '0;
      buf_valid_q <= 1'b0;
      buf_data_q  <= '0;
      drop_cnt_q  <= '0;
    end else begin
      ms_valid_q  <= ms_valid_d;
      bus_q       <= bus_d;
      buf_valid_q <= buf_valid_d;
      buf_data_q  <= buf_data_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Randomised bench for mem_stage: EX, WB and data-SRAM are modelled here, with an
// ownership queue of outstanding requests deciding which responses are live.
module tb_mem_stage;
  localparam int WD = 171;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  mem_stage_if #(.ES_TO_MS_WD(WD)) bus_if ();
  mem_stage #(.ES_TO_MS_WD(WD), .ERTN_BIT(80)) dut (
    .clk    (clk),
    .resetn (resetn),
    .ms_if  (bus_if.slave)
  );

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  // Reference state: MS slot, EX slot, and request-owner queue (instruction ids).
  logic          m_v, m_got, es_v;
  logic [WD-1:0] m_b, es_b;
  logic [31:0]   m_data;
  int unsigned   m_id, es_id, nid;
  int unsigned   q[$];

  logic          s_valid, s_allowin, s_ex;
  logic [39:0]   s_fwd;
  logic [WD-1:0] s_bus;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ld_val(input logic [WD-1:0] b, input logic [31:0] raw);
    int unsigned a;
    logic [31:0] by, hw;
    a  = b[77:76];
    by = (raw >> (8 * a)) & 32'hFF;
    hw = (raw >> (16 * (a / 2))) & 32'hFFFF;
    if (b[75]) return raw;
    if (b[74]) return (by >= 32'd128) ? by + 32'hFFFF_FF00 : by;
    if (b[73]) return by;
    if (b[72]) return (hw >= 32'h8000) ? hw + 32'hFFFF_0000 : hw;
    if (b[71]) return hw;
    return raw;
  endfunction

  // kind: 0 alu, 1 load, 2 store; ld one-hot {w,b,bu,h,hu}
  function automatic logic [WD-1:0] mk(input int kind, input logic [4:0] ld, input logic [1:0] a,
                                       input logic exf, input logic ertn);
    logic [WD-1:0] b;
    b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    b[70] = (kind == 1);
    b[78] = (kind == 2);
    b[69] = (kind != 2);
    b[75:71] = (kind == 1) ? ld : 5'd0;
    b[77:76] = a;
    b[79] = exf;
    b[80] = ertn;
    return b;
  endfunction

  task automatic give(input logic [WD-1:0] b);
    es_v  = 1'b1;
    es_b  = b;
    es_id = nid++;
    if ((b[70] | b[78]) & ~b[79]) q.push_back(es_id);
  endtask

  task automatic cycle(input logic ws, input logic fl, input logic dok_in, input logic [31:0] rd);
    logic dok, mreq, resp, rdy, ev, ea;
    logic [31:0] raw, fr;
    logic [WD-1:0] eb;
    dok = dok_in && (q.size() > 0) && !(es_v && q[0] == es_id);
    bus_if.ws_allowin        = ws;
    bus_if.flush             = fl;
    bus_if.es_to_ms_valid    = es_v;
    bus_if.es_to_ms_bus      = es_b;
    bus_if.data_sram_data_ok = dok;
    bus_if.data_sram_rdata   = rd;
    @(negedge clk);
    mreq = m_v && (m_b[70] || m_b[78]) && !m_b[79];
    resp = dok && m_v && (q[0] == m_id);
    rdy  = !mreq || m_got || resp;
    raw  = m_got ? m_data : rd;
    fr   = m_b[70] ? ld_val(m_b, raw) : m_b[63:32];
    ev   = m_v && rdy && !fl;
    ea   = !m_v || (rdy && ws);
    eb   = m_b;
    eb[63:32] = fr;
    eb[69]    = m_b[69] & ~m_b[79];
    s_valid   = bus_if.ms_to_ws_valid;
    s_allowin = bus_if.ms_allowin;
    s_fwd     = bus_if.ms_forward;
    s_bus     = bus_if.ms_to_ws_bus;
    s_ex      = bus_if.ms_to_es_ex;
    chk("to_ws_valid", s_valid, ev);
    chk("allowin", s_allowin, ea);
    chk("fwd_valid", s_fwd[0], m_v);
    chk("stall", s_fwd[39], m_v && m_b[70] && !rdy);
    chk("to_es_ex", s_ex, m_v && (m_b[79] || m_b[80]));
    if (ev) chk("ws_bus", s_bus, eb);
    if (m_v && rdy) chk("fwd_data", s_fwd[38:1], {fr, m_b[68:64], m_b[69]});
    @(posedge clk);
    if (dok) begin
      if (resp) begin
        m_got  = 1'b1;
        m_data = rd;
      end
      void'(q.pop_front());
    end
    if (fl) begin
      m_v  = 1'b0;
      es_v = 1'b0;
    end else if (ea) begin
      m_v = es_v;
      if (es_v) begin
        m_b   = es_b;
        m_id  = es_id;
        m_got = 1'b0;
      end
      es_v = 1'b0;
    end
    #1;
  endtask

  task automatic model_reset();
    m_v = 1'b0; m_got = 1'b0; es_v = 1'b0; m_b = '0; es_b = '0;
    q.delete();
  endtask

  initial begin
    int pulses;
    nid = 1;
    model_reset();
    resetn = 1'b0;
    bus_if.flush = 1'b0; bus_if.ws_allowin = 1'b1; bus_if.es_to_ms_valid = 1'b0;
    bus_if.es_to_ms_bus = '0; bus_if.data_sram_data_ok = 1'b0; bus_if.data_sram_rdata = '0;
    #12;
    chk("rst_valid", bus_if.ms_to_ws_valid, 1'b0);
    chk("rst_allowin", bus_if.ms_allowin, 1'b1);
    chk("rst_fwd0", bus_if.ms_forward[0], 1'b0);
    chk("rst_ex", bus_if.ms_to_es_ex, 1'b0);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk) #1;

    // Load extension cases.
    give(mk(1, 5'b01000, 2'd3, 1'b0, 1'b0)); cycle(1, 0, 0, 0);
    cycle(1, 0, 1, 32'h80FF_1234);
    chk("ld_b_valid", s_valid, 1'b1);
    chk("ld_b", s_fwd[38:7], 32'hFFFF_FF80);
    give(mk(1, 5'b00100, 2'd3, 1'b0, 1'b0)); cycle(1, 0, 0, 0);
    cycle(1, 0, 1, 32'h80FF_1234);
    chk("ld_bu", s_fwd[38:7], 32'h0000_0080);
    give(mk(1, 5'b00010, 2'd2, 1'b0, 1'b0)); cycle(1, 0, 0, 0);
    cycle(1, 0, 1, 32'h80FF_1234);
    chk("ld_h", s_bus[63:32], 32'hFFFF_80FF);

    // Response three cycles after entry.
    pulses = 0;
    give(mk(1, 5'b10000, 2'd0, 1'b0, 1'b0)); cycle(1, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      cycle(1, 0, 0, $urandom);
      chk("lat_stall", s_fwd[39], 1'b1);
      pulses += int'(s_valid);
    end
    cycle(1, 0, 1, 32'h0BAD_F00D);
    chk("lat_stall_end", s_fwd[39], 1'b0);
    pulses += int'(s_valid);
    cycle(1, 0, 0, 0);
    pulses += int'(s_valid);
    chk("lat_pulses", pulses, 1);

    // Response buffered across a WB stall.
    give(mk(1, 5'b10000, 2'd0, 1'b0, 1'b0)); cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 32'hDEAD_BEEF);
    cycle(0, 0, 0, 32'h0);
    cycle(1, 0, 0, 32'h0);
    chk("buf_valid", s_valid, 1'b1);
    chk("buf_data", s_bus[63:32], 32'hDEAD_BEEF);

    // Flush with a waiting load and a store arriving from EX.
    give(mk(1, 5'b10000, 2'd0, 1'b0, 1'b0)); cycle(1, 0, 0, 0);
    give(mk(2, 5'b0, 2'd0, 1'b0, 1'b0));
    cycle(1, 1, 0, 0);
    chk("drop_two", dut.drop_cnt_q, 2'd2);
    give(mk(1, 5'b10000, 2'd0, 1'b0, 1'b0)); cycle(1, 0, 0, 0);
    cycle(1, 0, 1, 32'h1111_1111);
    chk("drop1_valid", s_valid, 1'b0);
    cycle(1, 0, 1, 32'h2222_2222);
    chk("drop0", dut.drop_cnt_q, 2'd0);
    cycle(1, 0, 1, 32'h1234_5678);
    chk("after_drop", s_bus[63:32], 32'h1234_5678);

    // Exception instruction passes without a response.
    give(mk(1, 5'b10000, 2'd0, 1'b1, 1'b0)); cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    chk("ex_to_es", s_ex, 1'b1);
    chk("ex_valid", s_valid, 1'b1);
    chk("ex_gr_we", s_bus[69], 1'b0);

    // Asynchronous reset with orphans outstanding and a load waiting.
    give(mk(1, 5'b10000, 2'd0, 1'b0, 1'b0)); cycle(1, 0, 0, 0);
    give(mk(1, 5'b10000, 2'd0, 1'b0, 1'b0)); cycle(1, 1, 0, 0);
    give(mk(1, 5'b10000, 2'd0, 1'b0, 1'b0)); cycle(1, 0, 0, 0);
    #2 resetn = 1'b0;
    #1;
    chk("arst_valid", bus_if.ms_to_ws_valid, 1'b0);
    chk("arst_allowin", bus_if.ms_allowin, 1'b1);
    chk("arst_fwd0", bus_if.ms_forward[0], 1'b0);
    chk("arst_drop", dut.drop_cnt_q, 2'd0);
    model_reset();
    bus_if.es_to_ms_valid = 1'b0; bus_if.data_sram_data_ok = 1'b0; bus_if.flush = 1'b0;
    @(negedge clk) resetn = 1'b1;
    @(posedge clk) #1;

    // Random traffic.
    for (int n = 0; n < 4000; n++) begin
      if (!es_v && $urandom_range(0, 9) < 6)
        give(mk($urandom_range(0, 2), 5'b00001 << $urandom_range(0, 4), 2'($urandom_range(0, 3)),
                $urandom_range(0, 9) == 0, $urandom_range(0, 15) == 0));
      cycle($urandom_range(0, 9) < 7, ($urandom_range(0, 15) == 0) && (q.size() <= 3),
            $urandom_range(0, 1) == 1, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
